// File: rtl/somador_serial.sv
// somador_serial: bit-serial adder/subtractor. A single full-adder cell
// (somadorcompleto) is reused over WIDTH clocks, LSB first, with the carry
// held in a flip-flop between bits.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   operation request, sampled only when not busy
//   sub      in   0 = a+b, 1 = a-b, sampled with start
//   a, b     in   WIDTH-bit operands, sampled with start
//   busy     out  high while bits are being processed
//   done     out  one-cycle pulse when s/cout/overflow become valid
//   s        out  WIDTH-bit result register
//   cout     out  final carry out (subtract: 1 = no borrow)
//   overflow out  two's-complement overflow flag

// Single-bit full adder cell.
module somadorcompleto (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module somador_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMANDO = 2'd1,
        FIM     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_s_c;
    logic               fa_cout_c;

    // The one shared adder cell works on the current LSBs and held carry.
    somadorcompleto u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s_c),
        .cout (fa_cout_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCIOSO;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            OCIOSO, FIM: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b, seed the carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SOMANDO;
                end else begin
                    state_d = OCIOSO;
                end
            end
            SOMANDO: begin
                carry_d = fa_cout_c;
                s_d     = {fa_s_c, s_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB.
                    cout_d  = fa_cout_c;
                    ovf_d   = fa_cout_c ^ carry_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIM;
                end
            end
            default: begin
                state_d = OCIOSO;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign s        = s_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
